ofm_writeback: RTL

- Sits directly downstream of the PE array that consumes the skewed activation stream.
- Collects the skewed 16-lane partial-sum rows from the array and de-skews them into aligned rows.
- Requantizes each 32-bit psum to int8 and writes each packed 128-bit row into two 64-bit output SRAM banks.
- Runs one transfer of tran_time rows per start pulse and reports completion on done.

---
 rtl/ofm_writeback.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ofm_writeback.sv
// De-skews the PE array's 16-lane psum rows, requantizes each psum to int8 and
// writes each aligned row as two 64-bit halves to the output SRAM banks.
module ofm_writeback #(
   parameter int LANES  = 16,
   parameter int PSUM_W = 32,
   parameter int ADDR_W = 15
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [11:0]               tran_time,
   input  logic [ADDR_W-1:0]         base_addr,
   input  logic [4:0]                shift,
   input  logic [LANES-1:0]          res_valid_i,
   input  logic [LANES*PSUM_W-1:0]   res_data_i,
   output logic                      bwe_0,
   output logic                      bwe_1,
   output logic [ADDR_W-1:0]         bwaddr_0,
   output logic [ADDR_W-1:0]         bwaddr_1,
   output logic [LANES*4-1:0]        bwdata_0,
   output logic [LANES*4-1:0]        bwdata_1,
   output logic                      busy,
   output logic                      done,
   output logic                      err
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic signed [PSUM_W:0] SAT_HI = (PSUM_W+1)'(127);
   localparam logic signed [PSUM_W:0] SAT_LO = -(PSUM_W+1)'(128);

   logic [LANES-1:0]             dv;
   logic [LANES-1:0][PSUM_W-1:0] dd;

   // Lane i is delayed LANES-1-i cycles so every lane lines up with lane LANES-1.
   for (genvar g = 0; g < LANES; g++) begin : g_lane
      localparam int unsigned D = LANES - 1 - g;
      if (D == 0) begin : g_thru
         assign dv[g] = res_valid_i[g];
         assign dd[g] = res_data_i[PSUM_W*g +: PSUM_W];
      end else begin : g_dly
         logic [PSUM_W-1:0] d_q [D];
         logic [D-1:0]      v_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               v_q <= '0;
               for (int unsigned k = 0; k < D; k++) d_q[k] <= '0;
            end else begin
               v_q[0] <= res_valid_i[g];
               d_q[0] <= res_data_i[PSUM_W*g +: PSUM_W];
               for (int unsigned k = 1; k < D; k++) begin
                  v_q[k] <= v_q[k-1];
                  d_q[k] <= d_q[k-1];
               end
            end
         end
         assign dv[g] = v_q[D-1];
         assign dd[g] = d_q[D-1];
      end
   end

   logic row_valid;
   logic row_bad;
   assign row_valid = &dv;
   assign row_bad   = (|dv) & ~(&dv);

   state_t              state_q;
   logic [ADDR_W-1:0]   base_q;
   logic [4:0]          shift_q;
   logic [11:0]         tran_q;
   logic [11:0]         row_cnt_q;
   logic                bwe_q;
   logic [ADDR_W-1:0]   bwaddr_q;
   logic [LANES*8-1:0]  bwdata_q;
   logic                busy_q;
   logic                done_q;
   logic                err_q;

   logic [LANES*8-1:0]      q_row;
   logic signed [PSUM_W:0]  ps;
   logic signed [PSUM_W:0]  rnd;
   logic signed [PSUM_W:0]  y;

   // Round-half-up then arithmetic shift in PSUM_W+1 bits, saturate to int8.
   always_comb begin
      q_row = '0;
      ps    = '0;
      rnd   = '0;
      y     = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         ps  = $signed({dd[l][PSUM_W-1], dd[l]});
         rnd = (shift_q == '0) ? '0 : ((PSUM_W+1)'(1) <<< (shift_q - 5'd1));
         y   = (ps + rnd) >>> shift_q;
         if (y > SAT_HI)      q_row[8*l +: 8] = 8'h7F;
         else if (y < SAT_LO) q_row[8*l +: 8] = 8'h80;
         else                 q_row[8*l +: 8] = y[7:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         base_q    <= '0;
         shift_q   <= '0;
         tran_q    <= '0;
         row_cnt_q <= '0;
         bwe_q     <= 1'b0;
         bwaddr_q  <= '0;
         bwdata_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         bwe_q  <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (row_valid) err_q <= 1'b1;
               if (start) begin
                  err_q <= row_valid;
                  if (tran_time == '0) begin
                     state_q <= S_DONE;
                  end else begin
                     base_q    <= base_addr;
                     shift_q   <= shift;
                     tran_q    <= tran_time;
                     row_cnt_q <= '0;
                     busy_q    <= 1'b1;
                     state_q   <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (row_valid) begin
                  bwe_q     <= 1'b1;
                  bwaddr_q  <= base_q + ADDR_W'(row_cnt_q);
                  bwdata_q  <= q_row;
                  row_cnt_q <= row_cnt_q + 12'd1;
                  if (row_cnt_q == tran_q - 12'd1) begin
                     busy_q  <= 1'b0;
                     state_q <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (row_valid) err_q <= 1'b1;
               done_q  <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
         // Misaligned valids win over the clear-on-start above.
         if (row_bad) err_q <= 1'b1;
      end
   end

   assign bwe_0    = bwe_q;
   assign bwe_1    = bwe_q;
   assign bwaddr_0 = bwaddr_q;
   assign bwaddr_1 = bwaddr_q;
   assign bwdata_0 = bwdata_q[LANES*4-1:0];
   assign bwdata_1 = bwdata_q[LANES*8-1:LANES*4];
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule
